// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants for the MIPS-style core: opcodes, funct codes, ALU
// operation encodings and the bit/field positions of the packed control word.
package cpu_isa_pkg;

  localparam logic [5:0] OP_LW    = 6'b101111;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_BNE   = 6'b110001;
  localparam logic [5:0] OP_RTYPE = 6'b011001;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_MUL = 6'b110010;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_MUL = 3'b100
  } alu_op_e;

  // Control word layout, consumed by the datapath, memory and branch logic.
  localparam int unsigned CTRL_REG_WRITE   = 0;
  localparam int unsigned CTRL_MEM_READ    = 1;
  localparam int unsigned CTRL_MEM_WRITE   = 2;
  localparam int unsigned CTRL_MEM_TO_REG  = 3;
  localparam int unsigned CTRL_ALU_SRC_IMM = 4;
  localparam int unsigned CTRL_BRANCH_NE   = 5;
  localparam int unsigned CTRL_REG_DST_RD  = 6;
  localparam int unsigned CTRL_ALU_OP_LSB  = 7;
  localparam int unsigned CTRL_RS_LSB      = 10;
  localparam int unsigned CTRL_RT_LSB      = 15;
  localparam int unsigned CTRL_WREG_LSB    = 20;
  localparam int unsigned CTRL_ILLEGAL     = 25;

endpackage

// File: rtl/control_decode.sv
// Purely combinational instruction decoder: instruction word -> next control
// word, jump flag and jump target.
module control_decode
  import cpu_isa_pkg::*;
(
  input  logic [31:0] instruction,
  output logic [31:0] ctrl_next,
  output logic        jmp_next,
  output logic [31:0] addr_next
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op    = instruction[31:26];
  assign rs    = instruction[25:21];
  assign rt    = instruction[20:16];
  assign rd    = instruction[15:11];
  assign funct = instruction[5:0];

  logic    reg_write;
  logic    mem_read;
  logic    mem_write;
  logic    mem_to_reg;
  logic    alu_src_imm;
  logic    branch_ne;
  logic    reg_dst_rd;
  logic    illegal;
  logic    copy_regs;
  alu_op_e alu_op;
  logic [4:0] wreg;

  always_comb begin
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    alu_src_imm = 1'b0;
    branch_ne   = 1'b0;
    reg_dst_rd  = 1'b0;
    illegal     = 1'b0;
    copy_regs   = 1'b0;
    alu_op      = ALU_ADD;
    wreg        = '0;
    jmp_next    = 1'b0;
    addr_next   = '0;

    // The all-zero word is a NOP even though its opcode is not otherwise defined.
    if (instruction != '0) begin
      case (op)
        OP_LW: begin
          copy_regs   = 1'b1;
          reg_write   = 1'b1;
          mem_read    = 1'b1;
          mem_to_reg  = 1'b1;
          alu_src_imm = 1'b1;
          wreg        = rt;
        end
        OP_SW: begin
          copy_regs   = 1'b1;
          mem_write   = 1'b1;
          alu_src_imm = 1'b1;
        end
        OP_BNE: begin
          copy_regs = 1'b1;
          branch_ne = 1'b1;
          alu_op    = ALU_SUB;
        end
        OP_RTYPE: begin
          copy_regs  = 1'b1;
          reg_write  = 1'b1;
          reg_dst_rd = 1'b1;
          wreg       = rd;
          case (funct)
            FN_ADD: alu_op = ALU_ADD;
            FN_SUB: alu_op = ALU_SUB;
            FN_AND: alu_op = ALU_AND;
            FN_OR:  alu_op = ALU_OR;
            FN_MUL: alu_op = ALU_MUL;
            default: begin
              illegal    = 1'b1;
              reg_write  = 1'b0;
              reg_dst_rd = 1'b0;
              wreg       = '0;
            end
          endcase
        end
        OP_J: begin
          jmp_next  = 1'b1;
          addr_next = {6'b0, instruction[25:0]};
        end
        default: illegal = 1'b1;
      endcase
    end

    // $zero is never a write destination.
    if (wreg == '0) begin
      reg_write = 1'b0;
    end
  end

  always_comb begin
    ctrl_next                                = '0;
    ctrl_next[CTRL_REG_WRITE]                = reg_write;
    ctrl_next[CTRL_MEM_READ]                 = mem_read;
    ctrl_next[CTRL_MEM_WRITE]                = mem_write;
    ctrl_next[CTRL_MEM_TO_REG]               = mem_to_reg;
    ctrl_next[CTRL_ALU_SRC_IMM]              = alu_src_imm;
    ctrl_next[CTRL_BRANCH_NE]                = branch_ne;
    ctrl_next[CTRL_REG_DST_RD]               = reg_dst_rd;
    ctrl_next[CTRL_ALU_OP_LSB +: 3]          = alu_op;
    ctrl_next[CTRL_RS_LSB +: 5]              = copy_regs ? rs : 5'd0;
    ctrl_next[CTRL_RT_LSB +: 5]              = copy_regs ? rt : 5'd0;
    ctrl_next[CTRL_WREG_LSB +: 5]            = wreg;
    ctrl_next[CTRL_ILLEGAL]                  = illegal;
  end

endmodule

// File: rtl/control_unit.sv
// Control unit top: registers the combinational decode of the instruction
// word, giving one cycle of latency. Synchronous active-high reset.
module control_unit
  import cpu_isa_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instruction,
  output logic [31:0] ctrl,
  output logic [31:0] jmpAddress,
  output logic        jmpFlag
);

  logic [31:0] ctrl_next;
  logic        jmp_next;
  logic [31:0] addr_next;

  control_decode u_decode (
    .instruction (instruction),
    .ctrl_next   (ctrl_next),
    .jmp_next    (jmp_next),
    .addr_next   (addr_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl       <= '0;
      jmpAddress <= '0;
      jmpFlag    <= 1'b0;
    end else begin
      ctrl       <= ctrl_next;
      jmpAddress <= addr_next;
      jmpFlag    <= jmp_next;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vectors plus randomized
// instruction stream compared against a rule-level reference model.
module tb_control_unit;

  logic        clk;
  logic        rst;
  logic [31:0] instruction;
  logic [31:0] ctrl;
  logic [31:0] jmpAddress;
  logic        jmpFlag;

  int checks   = 0;
  int failures = 0;

  control_unit dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .ctrl        (ctrl),
    .jmpAddress  (jmpAddress),
    .jmpFlag     (jmpFlag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference decode built from the field rules with plain arithmetic.
  function automatic void model(input logic [31:0] ins, output logic [31:0] c,
                                output logic jf, output logic [31:0] ja);
    int unsigned op, rs, rt, rd, fn, alu, wreg;
    int unsigned rw, mr, mw, mtr, imm, bne, dst, ill, keep;
    int unsigned word;
    op = ins / 67108864; rs = (ins / 2097152) % 32; rt = (ins / 65536) % 32;
    rd = (ins / 2048) % 32; fn = ins % 64;
    {rw, mr, mw, mtr, imm, bne, dst, ill, keep} = '0;
    alu = 0; wreg = 0;
    jf = 1'b0; ja = 32'd0;
    if (ins == 0) begin
      // NOP: everything stays zero
    end else if (op == 47) begin
      keep = 1; rw = 1; mr = 1; mtr = 1; imm = 1; wreg = rt;
    end else if (op == 48) begin
      keep = 1; mw = 1; imm = 1;
    end else if (op == 49) begin
      keep = 1; bne = 1; alu = 1;
    end else if (op == 25) begin
      keep = 1;
      if      (fn == 32) alu = 0;
      else if (fn == 34) alu = 1;
      else if (fn == 36) alu = 2;
      else if (fn == 37) alu = 3;
      else if (fn == 50) alu = 4;
      else ill = 1;
      if (ill == 0) begin rw = 1; dst = 1; wreg = rd; end
    end else if (op == 2) begin
      jf = 1'b1; ja = ins % 67108864;
    end else begin
      ill = 1;
    end
    if (wreg == 0) rw = 0;
    if (keep == 0) begin rs = 0; rt = 0; end
    word = rw + mr*2 + mw*4 + mtr*8 + imm*16 + bne*32 + dst*64 + alu*128
         + rs*1024 + rt*32768 + wreg*1048576 + ill*33554432;
    c = word;
  endfunction

  task automatic check(input string tag, input logic [31:0] ec,
                       input logic ejf, input logic [31:0] eja);
    checks++;
    assert (ctrl === ec) else begin
      failures++;
      $error("FAIL %s ctrl got=%h exp=%h", tag, ctrl, ec);
    end
    checks++;
    assert (jmpFlag === ejf) else begin
      failures++;
      $error("FAIL %s jmpFlag got=%b exp=%b", tag, jmpFlag, ejf);
    end
    checks++;
    assert (jmpAddress === eja) else begin
      failures++;
      $error("FAIL %s jmpAddress got=%h exp=%h", tag, jmpAddress, eja);
    end
  endtask

  // Apply one instruction for one clock, check after the edge, then scramble
  // the input and confirm the outputs are held by the register.
  task automatic step(input string tag, input logic [31:0] ins, input logic r,
                      input logic [31:0] ec, input logic ejf, input logic [31:0] eja);
    instruction = ins;
    rst         = r;
    @(posedge clk);
    #1;
    check(tag, ec, ejf, eja);
    instruction = $urandom;
    #1;
    check({tag, "_hold"}, ec, ejf, eja);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int unsigned k;
    logic [5:0] fn_tab [5];
    fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h32};
    ins = $urandom;
    k   = $urandom_range(0, 7);
    case (k)
      0: ins[31:26] = 6'b101111;
      1: ins[31:26] = 6'b110000;
      2: ins[31:26] = 6'b110001;
      3, 4: begin
        ins[31:26] = 6'b011001;
        if ($urandom_range(0, 3) != 0) ins[5:0] = fn_tab[$urandom_range(0, 4)];
      end
      5: ins[31:26] = 6'b000010;
      6: ins = '0;
      default: ;
    endcase
    if ($urandom_range(0, 5) == 0) ins[20:16] = 5'd0;
    if ($urandom_range(0, 5) == 0) ins[15:11] = 5'd0;
    return ins;
  endfunction

  initial begin
    logic [31:0] ins, ec, eja;
    logic        ejf, r;
    rst         = 1'b1;
    instruction = '0;

    step("reset",     32'hBC010000, 1'b1, 32'h00000000, 1'b0, 32'h0);
    step("lw",        32'hBC010000, 1'b0, 32'h0010801B, 1'b0, 32'h0);
    step("sw",        32'hC0218001, 1'b0, 32'h00008414, 1'b0, 32'h0);
    step("bne",       32'hC4220008, 1'b0, 32'h000104A0, 1'b0, 32'h0);
    step("r_add",     32'h64223020, 1'b0, 32'h00610441, 1'b0, 32'h0);
    step("r_mul",     32'h64221832, 1'b0, 32'h00310641, 1'b0, 32'h0);
    step("r_sub",     32'h64223822, 1'b0, 32'h007104C1, 1'b0, 32'h0);
    step("r_and",     32'h64224024, 1'b0, 32'h00810541, 1'b0, 32'h0);
    step("r_or",      32'h64224825, 1'b0, 32'h009105C1, 1'b0, 32'h0);
    step("r_badfn",   32'h6422003F, 1'b0, 32'h02010400, 1'b0, 32'h0);
    step("r_rd0",     32'h64220020, 1'b0, 32'h00010440, 1'b0, 32'h0);
    step("lw_rt0",    32'hBC200000, 1'b0, 32'h0000041A, 1'b0, 32'h0);
    step("bad_op",    32'hFC000000, 1'b0, 32'h02000000, 1'b0, 32'h0);
    step("j",         32'h080033AF, 1'b0, 32'h00000000, 1'b1, 32'h000033AF);
    step("nop",       32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'h0);
    step("j_max",     32'h0BFFFFFF, 1'b0, 32'h00000000, 1'b1, 32'h03FFFFFF);
    step("rst_after_j", 32'h080033AF, 1'b1, 32'h00000000, 1'b0, 32'h0);
    step("lw_again",  32'hBC010000, 1'b0, 32'h0010801B, 1'b0, 32'h0);
    step("rst_mid",   32'h64223020, 1'b1, 32'h00000000, 1'b0, 32'h0);
    step("resume",    32'hC4220008, 1'b0, 32'h000104A0, 1'b0, 32'h0);

    for (int i = 0; i < 300; i++) begin
      ins = rand_instr();
      r   = ($urandom_range(0, 19) == 0);
      if (r) begin
        ec = '0; ejf = 1'b0; eja = '0;
      end else begin
        model(ins, ec, ejf, eja);
      end
      step("rand", ins, r, ec, ejf, eja);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
